memory_sdp: RTL and testbench

Parametrised simple-dual-port synchronous RAM, the successor to the single-port 64x32 memory.
- One write port with byte enables; one independent read port.
- Configurable read latency and read-during-write (RDW) policy.
- Self-clearing initialisation after reset, with valid-tagged read data.
- Drop-in storage for register files, FIFOs and lookup tables across the design.

---
 rtl/memory_sdp.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_memory_sdp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_sdp.sv
// -----------------------------------------------------------------------------
// memory_sdp -- parametrised simple-dual-port synchronous RAM
//
// One write port with per-byte enables and one independent read port.
// After reset an internal sequencer walks the whole array and writes zero
// to every word. busy_o is high while that runs, and all requests are ignored
// during that time. Read data is tagged with a one-cycle rd_valid_o pulse.
//
// Parameters
//   DATA_W      data width in bits, multiple of 8
//   DEPTH       number of words (need not be a power of 2)
//   ADDR_W      address width
//   RD_LATENCY  1 or 2 cycles from request edge to visible data
//   RDW_MODE    same-address read-during-write: 0 = old data, 1 = new data
//
// Ports
//   clk_i        clock, all logic on posedge
//   rst_i        asynchronous active-high reset
//   wr_en_i      write request
//   wr_addr_i    write address
//   wr_be_i      byte enables, bit k covers data bits 8k+7:8k
//   wr_data_i    write data
//   rd_en_i      read request
//   rd_addr_i    read address
//   rd_data_o    read data, holds its last value while rd_valid_o=0
//   rd_valid_o   one-cycle pulse per accepted read
//   busy_o       initialisation in progress
//   par_err_o    (MEMORY_SDP_PARITY_EN only) parity error on the read word,
//                aligned with rd_valid_o
//
// Optional feature macro: MEMORY_SDP_PARITY_EN
//   When defined, each byte is stored with one even-parity bit. The read path
//   reports a parity failure on par_err_o.
//
// Request handshake: a request is taken on every rising edge where its enable
// is high and the block is in READY. There is no back-pressure. Reads come back
// in request order, exactly RD_LATENCY cycles after the request.
// -----------------------------------------------------------------------------
module memory_sdp #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o,
    output logic                busy_o
`ifdef MEMORY_SDP_PARITY_EN
    ,
    output logic                par_err_o
`endif
);

    localparam int NB = DATA_W / 8;
`ifdef MEMORY_SDP_PARITY_EN
    // Parity bits sit above the data bits: bit DATA_W+k covers byte k.
    localparam int MEM_W = DATA_W + NB;
`else
    localparam int MEM_W = DATA_W;
`endif
    // The address is widened by one bit so that the range check also works
    // when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("memory_sdp: RD_LATENCY must be 1 or 2");
        end
        if (DATA_W % 8 != 0) begin : g_bad_width
            $error("memory_sdp: DATA_W must be a multiple of 8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Init / ready sequencer
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_o    = 1'b0;
        case (state)
            ST_INIT: begin
                busy_o = 1'b1;
                if (cnt == LAST_A) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                busy_o = 1'b0;
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
                busy_o    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic ready;
    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;
    logic rd_ok;
    logic same_addr;

    assign ready       = (state == ST_READY);
    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_X);
    assign wr_ok       = ready & wr_en_i & wr_in_range;
    assign rd_ok       = ready & rd_en_i;
    assign same_addr   = (wr_addr_i == rd_addr_i);

    // Write word as it would be stored, including parity when enabled.
    logic [MEM_W-1:0] wr_word;

    always_comb begin
        wr_word              = '0;
        wr_word[DATA_W-1:0]  = wr_data_i;
`ifdef MEMORY_SDP_PARITY_EN
        for (int k = 0; k < NB; k++) begin
            wr_word[DATA_W + k] = ^wr_data_i[8*k +: 8];
        end
`endif
    end

    // ------------------------------------------------------------------
    // Storage array (no reset: cleared by the INIT sweep instead)
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            // An all-zero word also carries valid even parity.
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) begin
                    mem[wr_addr_i][8*k +: 8] <= wr_word[8*k +: 8];
`ifdef MEMORY_SDP_PARITY_EN
                    mem[wr_addr_i][DATA_W + k] <= wr_word[DATA_W + k];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array-read stage. The read-during-write policy is resolved here.
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] rd_raw;
    logic [MEM_W-1:0] rd_word;

    always_comb begin
        rd_raw  = rd_in_range ? mem[rd_addr_i] : '0;
        rd_word = rd_raw;
        // Write-first: overlay the bytes that are being written this edge.
        // The array itself only changes after the edge, so old data needs
        // no special handling.
        if (RDW_MODE == 1 && wr_ok && same_addr) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) begin
                    rd_word[8*k +: 8] = wr_word[8*k +: 8];
`ifdef MEMORY_SDP_PARITY_EN
                    rd_word[DATA_W + k] = wr_word[DATA_W + k];
`endif
                end
            end
        end
    end

`ifdef MEMORY_SDP_PARITY_EN
    logic rd_perr;

    always_comb begin
        rd_perr = 1'b0;
        for (int k = 0; k < NB; k++) begin
            rd_perr = rd_perr | (^{rd_word[DATA_W + k], rd_word[8*k +: 8]});
        end
    end
`endif

    // First output register. Data is loaded only on an accepted read, so it
    // holds its last value between pulses.
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
`ifdef MEMORY_SDP_PARITY_EN
    logic              s1_perr;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
`ifdef MEMORY_SDP_PARITY_EN
            s1_perr  <= 1'b0;
`endif
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok) begin
                s1_data <= rd_word[DATA_W-1:0];
            end
`ifdef MEMORY_SDP_PARITY_EN
            s1_perr  <= rd_ok & rd_perr;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;
`ifdef MEMORY_SDP_PARITY_EN
            logic              s2_perr;
`endif

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
`ifdef MEMORY_SDP_PARITY_EN
                    s2_perr  <= 1'b0;
`endif
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
`ifdef MEMORY_SDP_PARITY_EN
                    s2_perr  <= s1_perr;
`endif
                end
            end

            assign rd_data_o  = s2_data;
            assign rd_valid_o = s2_valid;
`ifdef MEMORY_SDP_PARITY_EN
            assign par_err_o  = s2_perr;
`endif
        end else begin : g_lat1
            assign rd_data_o  = s1_data;
            assign rd_valid_o = s1_valid;
`ifdef MEMORY_SDP_PARITY_EN
            assign par_err_o  = s1_perr;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_memory_sdp.sv
// -----------------------------------------------------------------------------
// tb_memory_sdp -- self-checking bench for memory_sdp
//
// Two instances share one stimulus stream:
//   dut0: RD_LATENCY=1, RDW_MODE=0
//   dut1: RD_LATENCY=2, RDW_MODE=1
// DEPTH=48 is used so that out-of-range addresses are reachable.
// The reference model is a plain word array plus per-instance expected queues
// holding {due edge, parity error, data}.
// -----------------------------------------------------------------------------
module tb_memory_sdp;

    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int LAT0  = 1;
    localparam int LAT1  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be = '0;
    logic [31:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [31:0]   rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          busy0, busy1;
`ifdef MEMORY_SDP_PARITY_EN
    logic          par0, par1;
`endif

    memory_sdp #(.DATA_W(32), .DEPTH(DEPTH), .RD_LATENCY(LAT0), .RDW_MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .busy_o(busy0)
`ifdef MEMORY_SDP_PARITY_EN
        , .par_err_o(par0)
`endif
    );

    memory_sdp #(.DATA_W(32), .DEPTH(DEPTH), .RD_LATENCY(LAT1), .RDW_MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .busy_o(busy1)
`ifdef MEMORY_SDP_PARITY_EN
        , .par_err_o(par1)
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [DEPTH];
    logic [3:0]  ref_bad [DEPTH];   // bytes whose stored parity is broken
    logic [64:0] exp_q0[$];         // {due[64:33], perr[32], data[31:0]}
    logic [64:0] exp_q1[$];
    logic [31:0] last_data [2];
    int          init_left = DEPTH;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    // Value a read of rd_addr returns this edge, given the instance's RDW mode.
    function automatic logic [32:0] model_read(input int rdw);
        logic [31:0] d;
        logic [3:0]  b;
        if (int'(rd_addr) >= DEPTH) return 33'd0;
        d = ref_mem[rd_addr];
        b = ref_bad[rd_addr];
        if (rdw == 1 && wr_en && wr_addr == rd_addr) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    d[8*k +: 8] = wr_data[8*k +: 8];
                    b[k] = 1'b0;
                end
            end
        end
        return {|b, d};
    endfunction

    task automatic check_out(input int i, input int k);
        logic [64:0] e;
        logic        hit;
        logic        vld;
        logic [31:0] dat;
        logic        pe;
        e = '0;
        hit = 1'b0;
        pe = 1'b0;
        if (i == 0) begin
            vld = rd_valid0;
            dat = rd_data0;
`ifdef MEMORY_SDP_PARITY_EN
            pe = par0;
`endif
            if (exp_q0.size() > 0 && int'(exp_q0[0][64:33]) == k) begin
                e = exp_q0.pop_front();
                hit = 1'b1;
            end
        end else begin
            vld = rd_valid1;
            dat = rd_data1;
`ifdef MEMORY_SDP_PARITY_EN
            pe = par1;
`endif
            if (exp_q1.size() > 0 && int'(exp_q1[0][64:33]) == k) begin
                e = exp_q1.pop_front();
                hit = 1'b1;
            end
        end
        if (hit) last_data[i] = e[31:0];
        checks++;
        assert (vld === hit) else begin
            errors++;
            $error("FAIL rd_valid%0d edge %0d: observed %b expected %b", i, k, vld, hit);
        end
        checks++;
        assert (dat === last_data[i]) else begin
            errors++;
            $error("FAIL rd_data%0d edge %0d: observed %h expected %h", i, k, dat, last_data[i]);
        end
`ifdef MEMORY_SDP_PARITY_EN
        checks++;
        assert (pe === (hit & e[32])) else begin
            errors++;
            $error("FAIL par_err%0d edge %0d: observed %b expected %b", i, k, pe, hit & e[32]);
        end
`else
        if (pe) hit = 1'b0;
`endif
    endtask

    // Apply the model for the coming edge, take the edge, check at negedge.
    task automatic step();
        logic [32:0] r0;
        logic [32:0] r1;
        logic        exp_busy;
        edge_n++;
        if (rst_i == 1'b0) begin
            if (init_left > 0) begin
                ref_mem[DEPTH - init_left] = '0;
                ref_bad[DEPTH - init_left] = '0;
                init_left--;
            end else begin
                if (rd_en) begin
                    r0 = model_read(0);
                    r1 = model_read(1);
                    exp_q0.push_back({32'(edge_n + LAT0 - 1), r0});
                    exp_q1.push_back({32'(edge_n + LAT1 - 1), r1});
                end
                if (wr_en && int'(wr_addr) < DEPTH) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wr_be[k]) begin
                            ref_mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
                            ref_bad[wr_addr][k] = 1'b0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        exp_busy = (rst_i == 1'b1) || (init_left > 0);
        checks++;
        assert (busy0 === exp_busy) else begin
            errors++;
            $error("FAIL busy0 edge %0d: observed %b expected %b", edge_n, busy0, exp_busy);
        end
        checks++;
        assert (busy1 === exp_busy) else begin
            errors++;
            $error("FAIL busy1 edge %0d: observed %b expected %b", edge_n, busy1, exp_busy);
        end
        check_out(0, edge_n);
        check_out(1, edge_n);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic we, input int wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input int ra);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        step();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
    endtask

    task automatic rand_cyc(input int amax);
        int wa;
        int ra;
        wa = int'($urandom_range(0, amax));
        ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, amax));
        cyc(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), ra);
    endtask

    task automatic reset_now();
        rst_i = 1'b1;
        init_left = DEPTH;
        exp_q0.delete();
        exp_q1.delete();
        last_data[0] = '0;
        last_data[1] = '0;
        #1;
        checks++;
        assert (busy0 === 1'b1 && busy1 === 1'b1) else begin
            errors++;
            $error("FAIL reset_busy: observed %b%b expected 11", busy0, busy1);
        end
        checks++;
        assert (rd_valid0 === 1'b0 && rd_valid1 === 1'b0) else begin
            errors++;
            $error("FAIL reset_valid: observed %b%b expected 00", rd_valid0, rd_valid1);
        end
        checks++;
        assert (rd_data0 === 32'h0 && rd_data1 === 32'h0) else begin
            errors++;
            $error("FAIL reset_data: observed %h %h expected 0 0", rd_data0, rd_data1);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = '0;
            ref_bad[a] = '0;
        end
        last_data[0] = '0;
        last_data[1] = '0;

        // Power-on reset, held for two edges.
        #2;
        reset_now();
        @(negedge clk);
        step();
        step();
        rst_i = 1'b0;

        // INIT: random requests must be ignored, busy for exactly DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) rand_cyc(63);

        // Freshly cleared word.
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 17);
        expect_word("init_addr17", rd_data0, 32'h0000_0000);

        // Byte enables.
        cyc(1'b1, 5, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
        cyc(1'b1, 5, 4'h5, 32'h1122_3344, 1'b0, 0);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
        expect_word("be_merge_lat1", rd_data0, 32'hDE22_BE44);
        idle();
        expect_word("be_merge_lat2", rd_data1, 32'hDE22_BE44);

        // Back-to-back reads through the two-stage instance.
        for (int a = 0; a < 3; a++) cyc(1'b1, a, 4'hF, 32'hA0 + 32'(a), 1'b0, 0);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 0);
        expect_word("pipe_v0", 32'(rd_valid1), 32'h0);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 1);
        expect_word("pipe_d0", rd_data1, 32'hA0);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 2);
        expect_word("pipe_d1", rd_data1, 32'hA1);
        idle();
        expect_word("pipe_d2", rd_data1, 32'hA2);
        idle();
        expect_word("pipe_v_end", 32'(rd_valid1), 32'h0);

        // Same-edge collision on a zero word.
        cyc(1'b1, 9, 4'h3, 32'hCAFE_F00D, 1'b1, 9);
        expect_word("rdw_old", rd_data0, 32'h0000_0000);
        idle();
        expect_word("rdw_new", rd_data1, 32'h0000_F00D);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 9);
        expect_word("wr_then_rd", rd_data0, 32'h0000_F00D);
        idle();

        // Boundaries: last word and out-of-range.
        cyc(1'b1, DEPTH - 1, 4'hF, 32'h5A5A_1234, 1'b0, 0);
        cyc(1'b1, 50, 4'hF, 32'h1234_5678, 1'b1, DEPTH - 1);
        expect_word("last_word", rd_data0, 32'h5A5A_1234);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 50);
        expect_word("oor_data", rd_data0, 32'h0);
        expect_word("oor_valid", 32'(rd_valid0), 32'h1);
        idle();

        // Random traffic, partly concentrated on a few addresses.
        for (int i = 0; i < 150; i++) rand_cyc(7);
        for (int i = 0; i < 200; i++) rand_cyc(63);
        idle();
        idle();

        // Reset with reads in flight.
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 9);
        reset_now();
        step();
        step();
        rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) idle();
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
        expect_word("rezero_addr5", rd_data0, 32'h0);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 9);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, DEPTH - 1);
        idle();
        idle();

`ifdef MEMORY_SDP_PARITY_EN
        // Corrupt one stored data bit at address 3 in both instances.
        dut0.mem[3][0] = ~dut0.mem[3][0];
        dut1.mem[3][0] = ~dut1.mem[3][0];
        ref_mem[3][0]  = ~ref_mem[3][0];
        ref_bad[3][0]  = 1'b1;
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        expect_word("par_err_bad", 32'(par0), 32'h1);
        cyc(1'b0, 0, 4'h0, 32'h0, 1'b1, 4);
        expect_word("par_err_clean", 32'(par0), 32'h0);
        idle();
        idle();
`endif

        checks++;
        assert (exp_q0.size() == 0 && exp_q1.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
